// File: rtl/store_axi_writer_pkg.sv
// ----------------------------------------------------------------------------
// store_axi_writer_pkg
// Shared CPU-side types and AXI3 encodings used by the store writer and its
// bus interface.
//   virt_t / uint32_t : 32-bit address and data types
//   st_req_t          : one queued store {addr, wstrb, size, data}
//   AXI_*             : burst / response encodings and the default AXI ID
// ----------------------------------------------------------------------------
package store_axi_writer_pkg;

    typedef logic [31:0] virt_t;
    typedef logic [31:0] uint32_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_ID_DEFAULT = 4'd1;

    typedef struct packed {
        virt_t      addr;
        logic [3:0] wstrb;
        logic [2:0] size;
        uint32_t    data;
    } st_req_t;

    // Store size 0/1/2 maps straight onto AXI awsize 1/2/4 bytes.
    function automatic logic [2:0] axi_size(input logic [2:0] size);
        return {1'b0, size[1:0]};
    endfunction

endpackage

// File: rtl/store_axi_writer_if.sv
// ----------------------------------------------------------------------------
// store_axi_writer_if
// AXI3 write channels (AW, W, B) between the store writer and the bus.
//   master : drives AW/W payload + valids and bready
//   slave  : drives awready, wready and the B channel
// ----------------------------------------------------------------------------
interface store_axi_writer_if;
    import store_axi_writer_pkg::*;

    logic [3:0] awid;
    virt_t      awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic [1:0] awlock;
    logic [3:0] awcache;
    logic [2:0] awprot;
    logic       awvalid;
    logic       awready;

    logic [3:0] wid;
    uint32_t    wdata;
    logic [3:0] wstrb;
    logic       wlast;
    logic       wvalid;
    logic       wready;

    logic [3:0] bid;
    logic [1:0] bresp;
    logic       bvalid;
    logic       bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/store_axi_writer.sv
// ----------------------------------------------------------------------------
// store_axi_writer
// Turns committed stores into single-beat AXI3 writes. Stores are queued in a
// DEPTH-entry ring; AW and W issue from independent pointers and B responses
// retire entries in order, each producing a one-cycle data_ok.
// Ports:
//   clk, reset        : core clock, synchronous active-high reset
//   store_req/...     : store request in; addr_ok = accepted this cycle
//   data_ok           : pulse, oldest outstanding store completed
//   axi (master)      : AW / W / B channels
//   bus_err           : sticky, a non-OKAY bresp was seen
// ----------------------------------------------------------------------------
module store_axi_writer
    import store_axi_writer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter logic [3:0]  AXI_ID = AXI_ID_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       store_req,
    input  logic [3:0] store_wstrb,
    input  logic [2:0] store_size,
    input  virt_t      store_addr,
    input  uint32_t    store_data,
    output logic       addr_ok,
    output logic       data_ok,
    store_axi_writer_if.master axi,
    output logic       bus_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    st_req_t          queue_q [DEPTH];
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] awptr_q, awptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    // Entries accepted but not yet issued on each channel.
    logic [CNT_W-1:0] aw_pend_q, aw_pend_d;
    logic [CNT_W-1:0] w_pend_q, w_pend_d;
    logic             data_ok_q, data_ok_d;
    logic             bus_err_q, bus_err_d;

    st_req_t new_ent, aw_ent, w_ent;
    logic    accept, retire, aw_hs, w_hs;
    logic    aw_bypass, w_bypass, awvalid, wvalid, bready;

    assign new_ent = '{addr: store_addr, wstrb: store_wstrb, size: store_size, data: store_data};

    assign accept = store_req && (count_q < FULL_CNT) && !reset;

    // With nothing pending on a channel the AW/W payload comes straight from
    // the incoming store, so an accept can issue in the same cycle. The entry
    // is still written at the tail (== that channel's pointer), so if the
    // beat stalls the queue presents the identical payload next cycle.
    assign aw_bypass = (aw_pend_q == '0);
    assign w_bypass  = (w_pend_q == '0);
    assign aw_ent    = aw_bypass ? new_ent : queue_q[awptr_q];
    assign w_ent     = w_bypass  ? new_ent : queue_q[wptr_q];

    assign awvalid = !reset && (!aw_bypass || accept);
    assign wvalid  = !reset && (!w_bypass || accept);
    assign bready  = !reset;

    assign aw_hs  = awvalid && axi.awready;
    assign w_hs   = wvalid && axi.wready;
    // B beats with nothing outstanding are ignored so count never wraps.
    assign retire = axi.bvalid && bready && (count_q != '0);

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            tail_q    <= '0;
            awptr_q   <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            aw_pend_q <= '0;
            w_pend_q  <= '0;
            data_ok_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            tail_q    <= tail_d;
            awptr_q   <= awptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            data_ok_q <= data_ok_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Queue storage needs no reset; count/pend gate every read of it.
    always_ff @(posedge clk) begin
        if (accept) begin
            queue_q[tail_q] <= new_ent;
        end
    end

    // ---- next state ----
    // Completion is in order, so the head is implicit in count: no head
    // pointer is needed, the AW/W pointers already carry the payload.
    always_comb begin
        tail_d    = tail_q;
        awptr_d   = awptr_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;

        if (accept) tail_d  = tail_q + 1'b1;
        if (aw_hs)  awptr_d = awptr_q + 1'b1;
        if (w_hs)   wptr_d  = wptr_q + 1'b1;

        case ({accept, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case ({accept, aw_hs})
            2'b10:   aw_pend_d = aw_pend_q + 1'b1;
            2'b01:   aw_pend_d = aw_pend_q - 1'b1;
            default: aw_pend_d = aw_pend_q;
        endcase

        case ({accept, w_hs})
            2'b10:   w_pend_d = w_pend_q + 1'b1;
            2'b01:   w_pend_d = w_pend_q - 1'b1;
            default: w_pend_d = w_pend_q;
        endcase

        data_ok_d = retire;
        bus_err_d = bus_err_q || (retire && (axi.bresp != AXI_RESP_OKAY));
    end

    // ---- outputs ----
    assign addr_ok = accept;
    assign data_ok = data_ok_q;
    assign bus_err = bus_err_q;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = aw_ent.addr;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = axi_size(aw_ent.size);
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = awvalid;

    assign axi.wid    = AXI_ID;
    assign axi.wdata  = w_ent.data;
    assign axi.wstrb  = w_ent.wstrb;
    assign axi.wlast  = 1'b1;
    assign axi.wvalid = wvalid;

    assign axi.bready = bready;

    // bid is not checked (in-order completion); the other fields are
    // carried per entry but only half of them feed each channel.
    logic unused_ok;
    assign unused_ok = ^{axi.bid, aw_ent.size[2], aw_ent.wstrb, aw_ent.data,
                         w_ent.addr, w_ent.size};

endmodule

// File: tb/tb_store_axi_writer.sv
// ----------------------------------------------------------------------------
// tb_store_axi_writer
// Directed bench for store_axi_writer. A small AXI slave model answers each
// write with a B beat in the cycle after both its AW and W beats have been
// accepted; handshakes and data_ok pulses are logged for ordering checks.
// ----------------------------------------------------------------------------
module tb_store_axi_writer;
    import store_axi_writer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       store_req;
    logic [3:0] store_wstrb;
    logic [2:0] store_size;
    virt_t      store_addr;
    uint32_t    store_data;
    logic       addr_ok;
    logic       data_ok;
    logic       bus_err;
    logic [1:0] bresp_val;

    store_axi_writer_if axi();

    store_axi_writer #(.DEPTH(4), .AXI_ID(4'd1)) dut (
        .clk        (clk),
        .reset      (reset),
        .store_req  (store_req),
        .store_wstrb(store_wstrb),
        .store_size (store_size),
        .store_addr (store_addr),
        .store_data (store_data),
        .addr_ok    (addr_ok),
        .data_ok    (data_ok),
        .axi        (axi),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    // ---- slave model: B one cycle after both AW and W of a write ----
    int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
    always @(posedge clk) begin
        if (reset) begin
            aw_hs_n <= 0;
            w_hs_n  <= 0;
            b_hs_n  <= 0;
        end else begin
            if (axi.awvalid && axi.awready) aw_hs_n <= aw_hs_n + 1;
            if (axi.wvalid && axi.wready)   w_hs_n  <= w_hs_n + 1;
            if (axi.bvalid && axi.bready)   b_hs_n  <= b_hs_n + 1;
        end
    end
    assign axi.bvalid = !reset && (((aw_hs_n < w_hs_n) ? aw_hs_n : w_hs_n) > b_hs_n);
    assign axi.bresp  = bresp_val;
    assign axi.bid    = 4'd1;

    // ---- logs ----
    logic [31:0] aw_log [0:63];
    logic [31:0] w_log  [0:63];
    int aw_n = 0, w_n = 0, dok_cnt = 0;
    always @(posedge clk) begin
        if (!reset && axi.awvalid && axi.awready) begin
            aw_log[aw_n] <= axi.awaddr;
            aw_n <= aw_n + 1;
        end
        if (!reset && axi.wvalid && axi.wready) begin
            w_log[w_n] <= axi.wdata;
            w_n <= w_n + 1;
        end
        if (data_ok) dok_cnt <= dok_cnt + 1;
    end

    int n_checks = 0, n_fail = 0;
    int base, aw_base, w_base, got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic put(input logic [31:0] a, input logic [3:0] s, input logic [2:0] z,
                       input logic [31:0] d);
        store_req   = 1'b1;
        store_addr  = a;
        store_wstrb = s;
        store_size  = z;
        store_data  = d;
    endtask

    task automatic wait_dok(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (dok_cnt < target && k < budget) begin
            next_cycle();
            k++;
        end
        chk(tag, dok_cnt, target);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; store_req = 1'b0; store_wstrb = '0; store_size = '0;
        store_addr = '0; store_data = '0; bresp_val = 2'b00;
        axi.awready = 1'b0; axi.wready = 1'b0;

        // ---- reset state ----
        repeat (2) next_cycle();
        mid();
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_data_ok", data_ok, 0);
        chk("rst_bus_err", bus_err, 0);
        next_cycle();
        reset = 1'b0; axi.awready = 1'b1; axi.wready = 1'b1;
        mid();
        chk("post_rst_bready", axi.bready, 1);
        chk("post_rst_addr_ok_idle", addr_ok, 0);
        next_cycle();

        // ---- single word store, data_ok 2 cycles after addr_ok ----
        base = dok_cnt;
        put(32'h0000_1004, 4'b1111, 3'd2, 32'hDEAD_BEEF);
        mid();
        chk("t1_addr_ok", addr_ok, 1);
        chk("t1_awvalid", axi.awvalid, 1);
        chk("t1_awaddr", axi.awaddr, 32'h0000_1004);
        chk("t1_awsize", axi.awsize, 2);
        chk("t1_wdata", axi.wdata, 32'hDEAD_BEEF);
        chk("t1_wstrb", axi.wstrb, 4'b1111);
        chk("t1_const", {axi.awid, axi.awlen, axi.awburst, axi.awlock, axi.awcache,
                         axi.awprot, axi.wid, axi.wlast}, {4'd1, 8'd0, 2'b01, 2'b00,
                         4'd0, 3'd0, 4'd1, 1'b1});
        next_cycle();
        store_req = 1'b0;
        mid();
        chk("t1_dok_c1", data_ok, 0);
        next_cycle();
        mid();
        chk("t1_dok_c2", data_ok, 1);
        next_cycle();
        mid();
        chk("t1_dok_pulse", data_ok, 0);
        chk("t1_dok_total", dok_cnt, base + 1);
        next_cycle();

        // ---- five stores with AW stalled: only four accepted ----
        base = dok_cnt; aw_base = aw_n; w_base = w_n;
        axi.awready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put(32'h100 + 4 * i, 4'hF, 3'd2, 32'h1000 + i);
            mid();
            chk($sformatf("t2_addr_ok_%0d", i), addr_ok, (i < 4) ? 1 : 0);
            next_cycle();
        end
        repeat (4) next_cycle();
        mid();
        chk("t2_still_full", addr_ok, 0);
        chk("t2_aw_stable", axi.awaddr, 32'h100);
        chk("t2_w_independent", w_n - w_base, 4);
        chk("t2_no_dok_stalled", dok_cnt, base);
        next_cycle();
        axi.awready = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            mid();
            if (addr_ok) got = 1;
            next_cycle();
        end
        store_req = 1'b0;
        chk("t2_fifth_accept", got, 1);
        wait_dok(base + 5, 30, "t2_dok_count");
        for (int i = 0; i < 5; i++)
            chk($sformatf("t2_aw_order_%0d", i), aw_log[aw_base + i], 32'h100 + 4 * i);

        // ---- W before AW ----
        base = dok_cnt; aw_base = aw_n; w_base = w_n;
        axi.awready = 1'b0;
        put(32'h300, 4'hF, 3'd2, 32'h3333_3333);
        mid();
        chk("t3_addr_ok", addr_ok, 1);
        next_cycle();
        store_req = 1'b0;
        mid();
        chk("t3_w_first", w_n - w_base, 1);
        chk("t3_aw_not_yet", aw_n - aw_base, 0);
        chk("t3_aw_hold", axi.awaddr, 32'h300);
        chk("t3_wvalid_done", axi.wvalid, 0);
        next_cycle();
        next_cycle();
        axi.awready = 1'b1;
        wait_dok(base + 1, 10, "t3_dok");
        repeat (3) next_cycle();
        chk("t3_one_dok", dok_cnt, base + 1);
        chk("t3_aw_addr", aw_log[aw_base], 32'h300);

        // ---- byte store with SLVERR response ----
        base = dok_cnt;
        bresp_val = 2'b10;
        put(32'h0000_2003, 4'b1000, 3'd0, 32'hAB00_0000);
        mid();
        chk("t4_awsize", axi.awsize, 0);
        chk("t4_wstrb", axi.wstrb, 4'b1000);
        chk("t4_awaddr", axi.awaddr, 32'h0000_2003);
        chk("t4_bus_err_before", bus_err, 0);
        next_cycle();
        store_req = 1'b0;
        wait_dok(base + 1, 10, "t4_dok");
        chk("t4_bus_err", bus_err, 1);
        bresp_val = 2'b00;

        // ---- fill, retire while full, pointer wrap ----
        base = dok_cnt; aw_base = aw_n; w_base = w_n;
        axi.awready = 1'b0; axi.wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(32'h400 + 4 * i, 4'hF, 3'd2, 32'h4000 + i);
            mid();
            chk($sformatf("t5_fill_%0d", i), addr_ok, 1);
            next_cycle();
        end
        put(32'h410, 4'hF, 3'd2, 32'h4004);
        mid();
        chk("t5_full", addr_ok, 0);
        next_cycle();
        axi.awready = 1'b1; axi.wready = 1'b1;
        mid();
        chk("t5_issue_cycle", addr_ok, 0);
        next_cycle();
        mid();
        chk("t5_retire_cycle", addr_ok, 0);
        next_cycle();
        mid();
        chk("t5_unblock", addr_ok, 1);
        next_cycle();
        store_req = 1'b0;
        wait_dok(base + 5, 20, "t5_dok");
        chk("t5_wrap_awaddr", aw_log[aw_base + 4], 32'h410);
        chk("t5_wrap_wdata", w_log[w_base + 4], 32'h4004);
        chk("t5_bus_err_sticky", bus_err, 1);

        // ---- reset with three stores outstanding ----
        base = dok_cnt;
        axi.awready = 1'b0; axi.wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(32'h600 + 4 * i, 4'hF, 3'd2, 32'h6000 + i);
            next_cycle();
        end
        store_req = 1'b0;
        reset = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
        mid();
        chk("t6_rst_awvalid", axi.awvalid, 0);
        chk("t6_rst_wvalid", axi.wvalid, 0);
        chk("t6_rst_bready", axi.bready, 0);
        next_cycle();
        mid();
        chk("t6_rst_data_ok", data_ok, 0);
        chk("t6_rst_bus_err", bus_err, 0);
        next_cycle();
        reset = 1'b0;
        mid();
        chk("t6_post_awvalid", axi.awvalid, 0);
        chk("t6_post_wvalid", axi.wvalid, 0);
        repeat (4) next_cycle();
        chk("t6_no_dok", dok_cnt, base);
        put(32'h700, 4'hF, 3'd2, 32'h7777_7777);
        mid();
        chk("t6_addr_ok", addr_ok, 1);
        chk("t6_awaddr", axi.awaddr, 32'h700);
        next_cycle();
        store_req = 1'b0;
        mid();
        next_cycle();
        mid();
        chk("t6_dok", data_ok, 1);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_axi_writer.md
STORE_AXI_WRITER -- requirements
Module: store_axi_writer

Interface
REQ-001 Parameter DEPTH, default 4, outstanding-store queue depth; power of two, at least 2.
REQ-002 Parameter AXI_ID, default 4'd1, constant awid/wid value.
REQ-003 clk  input  1  core clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 store_req  input  1  committed store request from the store buffer.
REQ-006 store_wstrb  input  4  byte enables.
REQ-007 store_size  input  3  access size: 0 byte, 1 half, 2 word.
REQ-008 store_addr  input  32  physical byte address (virt_t).
REQ-009 store_data  input  32  write data (uint32_t).
REQ-010 addr_ok  output  1  request accepted this cycle.
REQ-011 data_ok  output  1  one-cycle pulse: oldest accepted store has completed.
REQ-012 awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  output  4/32/8/3/2/2/4/3  AXI3 write-address payload.
REQ-013 awvalid  output  1; awready  input  1.
REQ-014 wid/wdata/wstrb/wlast  output  4/32/4/1  AXI3 write-data payload.
REQ-015 wvalid  output  1; wready  input  1.
REQ-016 bid/bresp  input  4/2; bvalid  input  1; bready  output  1.
REQ-017 bus_err  output  1  sticky flag: a non-OKAY bresp was received.

Function
REQ-018 addr_ok shall equal store_req && (count < DEPTH); it is combinational and never depends on awready, wready or bvalid.
REQ-019 On addr_ok the entry {addr, wstrb, size, data} shall be written at the tail; the tail then advances modulo DEPTH.
REQ-020 AW channel: the awptr entry shall drive awvalid whenever any accepted entry has not yet issued AW; AW issue is complete on awvalid && awready, after which awptr advances.
REQ-021 W channel: the same rule as REQ-020, using its own independent wptr; AW and W may complete in either order or in the same cycle.
REQ-022 The AW/W payload shall stay stable while valid is high and unaccepted.
REQ-023 Constant fields: awlen 0, awburst INCR (2'b01), awlock 0, awcache 0, awprot 0, wlast 1; awsize = {1'b0, size[1:0]}; awaddr = addr unmodified; wstrb and wdata = entry values.
REQ-024 bready shall be held at 1 whenever not in reset.
REQ-025 Each B handshake shall register a data_ok pulse on the next cycle and retire the head entry.
REQ-026 Completions shall be in order; bid is not checked.
REQ-027 Minimum latency from addr_ok to data_ok is 2 cycles, with awready = wready = 1 and bvalid returned in the cycle after the AW/W handshake.
REQ-028 count shall increment on accept and decrement on retire; simultaneous accept and retire leave count unchanged.
REQ-029 When full (count == DEPTH), addr_ok shall be 0; a retire in the same cycle does not unblock the accept until the next cycle.
REQ-030 Pointers shall wrap from DEPTH-1 to 0 without a gap.
REQ-031 There is no flush input: accepted stores are architecturally committed and always complete.
REQ-032 bresp != 2'b00 shall set bus_err, which holds until reset; the data_ok pulse is still produced.

Reset
REQ-033 While reset is high:
- all pointers, count, data_ok, awvalid, wvalid and bus_err are 0;
- bready is 0;
- queue contents are don't-care.
REQ-034 Reset mid-transaction shall abandon all in-flight entries and produce no data_ok for them.
REQ-035 No output shall reflect pre-reset state in the first cycle after reset deasserts.

Structure
REQ-036 The AXI burst/size/resp encodings and AXI_ID shall live in the shared cpu package alongside virt_t and uint32_t.
REQ-037 The queue entry shall be a packed struct st_req_t, defined in the shared package.
REQ-038 The block is one module with no sub-module; the queue is an inline register array.

Verification
REQ-039 Single store, all readies 1: addr 0x0000_1004, wstrb 4'b1111, data 0xDEAD_BEEF -> awaddr 0x1004, awsize 2, wdata 0xDEADBEEF; data_ok exactly 2 cycles after addr_ok.
REQ-040 Five back-to-back stores, awready = 0 for 10 cycles -> addr_ok for 4 only (deasserts on the 5th); after release, 5 in-order data_ok pulses.
REQ-041 W before AW: wready = 1, awready delayed 3 cycles -> wdata issued first, one data_ok total, order preserved.
REQ-042 Byte store: size 0, addr 0x0000_2003, wstrb 4'b1000 -> awsize 0, wstrb 4'b1000; bresp 2'b10 -> data_ok pulses and bus_err = 1.
REQ-043 Fill to full, then retire and request in the same cycle -> count stays 4; addr_ok asserts the next cycle; pointer wrap 3->0 verified.
REQ-044 Reset asserted with 3 entries outstanding -> no data_ok; awvalid/wvalid = 0 next cycle; subsequent store completes normally.
